// File: rtl/tank_sprite_fetch.sv
// Tank sprite fetch stage: per-frame latch of tank state, rotated 32x32 ROM addressing,
// transparent-key masking with 3-cycle aligned output. Optional hit blink via TANK_BLINK_EN.
module tank_sprite_fetch #(
  parameter int          SPR_DIM      = 32,
  parameter logic [23:0] KEY_RGB      = 24'hFF0000,
  parameter int          BLINK_FRAMES = 60
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_start,
  input  logic        pix_valid_in,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  tank_x,
  input  logic [9:0]  tank_y,
  input  logic [1:0]  tank_dir,
  input  logic        tank_alive,
  input  logic        hit_pulse,
  output logic [18:0] rom_addr,
  input  logic [23:0] rom_data,
  output logic        pixel_on,
  output logic [23:0] pixel_rgb,
  output logic        pix_valid_out
);

  localparam int SB = $clog2(SPR_DIM);

  typedef enum logic {IDLE, ARMED} state_t;

  state_t      state, state_nxt;
  logic        latch_en;
  logic [9:0]  act_x, act_y;
  logic [1:0]  act_dir;
  logic        act_alive;
  logic        draw_alive;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    // NOTE: registers always use non-blocking assignment so every flop samples pre-edge values.
    else        state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, otherwise an unassigned path infers a latch.
  always_comb begin
    state_nxt = state;
    latch_en  = 1'b0;
    case (state)
      IDLE:    if (frame_start) begin
                 state_nxt = ARMED;
                 latch_en  = 1'b1;
               end
      ARMED:   latch_en = frame_start;
      default: state_nxt = IDLE;
    endcase
  end

  // Tank state only moves at frame boundaries so a frame never shows two positions.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      act_x     <= '0;
      act_y     <= '0;
      act_dir   <= '0;
      act_alive <= 1'b0;
    end else if (latch_en) begin
      act_x     <= tank_x;
      act_y     <= tank_y;
      act_dir   <= tank_dir;
      act_alive <= tank_alive;
    end
  end

`ifdef TANK_BLINK_EN
  localparam int BW = ($clog2(BLINK_FRAMES + 1) < 3) ? 3 : $clog2(BLINK_FRAMES + 1);
  logic [BW-1:0] blink_cnt;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)                              blink_cnt <= '0;
    else if (state == ARMED && hit_pulse)    blink_cnt <= BW'(BLINK_FRAMES);
    else if (frame_start && blink_cnt != '0) blink_cnt <= blink_cnt - 1'b1;
  end

  assign draw_alive = act_alive & ~((blink_cnt != '0) & blink_cnt[2]);
`else
  localparam int unused_blink_frames = BLINK_FRAMES;
  logic unused_hit;
  assign unused_hit = hit_pulse;
  assign draw_alive = act_alive;
`endif

  // Stage 1: sprite-local coordinates; the high bits being zero covers both dx<0 and dx>=SPR_DIM.
  logic signed [10:0] dx, dy;
  logic [SB-1:0]      col, row;
  logic               hit_s;
  logic [18:0]        addr_s;

  assign dx    = $signed({1'b0, DrawX}) - $signed({1'b0, act_x});
  assign dy    = $signed({1'b0, DrawY}) - $signed({1'b0, act_y});
  assign col   = dx[SB-1:0];
  assign row   = dy[SB-1:0];
  assign hit_s = (state == ARMED) & draw_alive & pix_valid_in
               & (dx[10:SB] == '0) & (dy[10:SB] == '0);

  // Inverting an SB-bit coordinate gives SPR_DIM-1 minus that coordinate.
  always_comb begin
    addr_s = '0;
    case (act_dir)
      2'd0: addr_s = 19'({row, col});
      2'd1: addr_s = 19'({~col, row});
      2'd2: addr_s = 19'({~row, ~col});
      2'd3: addr_s = 19'({col, ~row});
      default: addr_s = '0;
    endcase
  end

  logic hit1, valid1, hit2, valid2, opaque;

  assign opaque = hit2 & (rom_data != KEY_RGB);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rom_addr      <= '0;
      hit1          <= 1'b0;
      valid1        <= 1'b0;
      hit2          <= 1'b0;
      valid2        <= 1'b0;
      pixel_on      <= 1'b0;
      pixel_rgb     <= '0;
      pix_valid_out <= 1'b0;
    end else begin
      rom_addr      <= hit_s ? addr_s : '0;
      hit1          <= hit_s;
      valid1        <= pix_valid_in;
      hit2          <= hit1;
      valid2        <= valid1;
      pixel_on      <= opaque;
      pixel_rgb     <= opaque ? rom_data : '0;
      pix_valid_out <= valid2;
    end
  end

endmodule

// File: tb/tb_tank_sprite_fetch.sv
// Self-checking bench for tank_sprite_fetch: directed scenarios plus randomized frames
// scored against a coordinate-level model of the sprite placement and rotation.
module tb_tank_sprite_fetch;

  localparam logic [23:0] KEY = 24'hFF0000;
  localparam int          BF  = 8;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        frame_start = 1'b0, pix_valid_in = 1'b0, tank_alive = 1'b0, hit_pulse = 1'b0;
  logic [9:0]  DrawX = '0, DrawY = '0, tank_x = '0, tank_y = '0;
  logic [1:0]  tank_dir = '0;
  logic [18:0] rom_addr;
  logic [23:0] rom_data = '0;
  logic        pixel_on, pix_valid_out;
  logic [23:0] pixel_rgb;

  tank_sprite_fetch #(.SPR_DIM(32), .KEY_RGB(KEY), .BLINK_FRAMES(BF)) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .pix_valid_in(pix_valid_in),
    .DrawX(DrawX), .DrawY(DrawY), .tank_x(tank_x), .tank_y(tank_y), .tank_dir(tank_dir),
    .tank_alive(tank_alive), .hit_pulse(hit_pulse), .rom_addr(rom_addr), .rom_data(rom_data),
    .pixel_on(pixel_on), .pixel_rgb(pixel_rgb), .pix_valid_out(pix_valid_out)
  );

  always #5 Clk = ~Clk;

  logic [23:0] mem [1024];
  always @(posedge Clk) rom_data <= mem[rom_addr[9:0]];

  typedef struct {
    bit          on;
    logic [23:0] rgb;
    bit          valid;
  } pix_t;

  pix_t pq[$];
  bit   m_armed, m_alive;
  int   mx, my, mdir, mblink;
  int   n_cmp = 0, n_bad = 0;

  task automatic reset_model();
    pix_t z;
    z.on = 0; z.rgb = '0; z.valid = 0;
    m_armed = 0; m_alive = 0; mx = 0; my = 0; mdir = 0; mblink = 0;
    pq.delete();
    pq.push_back(z);
    pq.push_back(z);
  endtask

  // One clock: drive a scan sample, predict it from screen geometry, score the DUT.
  task automatic cycle(input int x, input int y, input bit v, input bit fs, input bit hp);
    int   dx, dy, addr;
    bit   hit, alive;
    pix_t e, got;
    DrawX = 10'(x); DrawY = 10'(y); pix_valid_in = v; frame_start = fs; hit_pulse = hp;
    alive = m_alive;
`ifdef TANK_BLINK_EN
    if (mblink != 0 && ((mblink >> 2) & 1) == 1) alive = 0;
`endif
    dx = x - mx;
    dy = y - my;
    hit = m_armed && alive && v && dx >= 0 && dx < 32 && dy >= 0 && dy < 32;
    addr = 0;
    if (hit) begin
      case (mdir)
        0: addr = dy * 32 + dx;
        1: addr = (31 - dx) * 32 + dy;
        2: addr = (31 - dy) * 32 + (31 - dx);
        default: addr = dx * 32 + (31 - dy);
      endcase
    end
    e.on = hit && (mem[addr] != KEY);
    e.rgb = e.on ? mem[addr] : 24'h0;
    e.valid = v;
`ifdef TANK_BLINK_EN
    if (m_armed && hp) mblink = BF;
    else if (fs && mblink > 0) mblink--;
`endif
    if (fs) begin
      m_armed = 1; mx = int'(tank_x); my = int'(tank_y); mdir = int'(tank_dir); m_alive = tank_alive;
    end
    @(posedge Clk); #1;
    n_cmp++;
    if (rom_addr !== 19'(addr)) begin
      n_bad++;
      $display("FAIL model_rom_addr at (%0d,%0d): got %0d want %0d", x, y, rom_addr, addr);
    end
    pq.push_back(e);
    got = pq.pop_front();
    n_cmp++;
    if (pixel_on !== got.on || pixel_rgb !== got.rgb || pix_valid_out !== got.valid) begin
      n_bad++;
      $display("FAIL model_pixel: got on=%0b rgb=%h v=%0b want on=%0b rgb=%h v=%0b",
               pixel_on, pixel_rgb, pix_valid_out, got.on, got.rgb, got.valid);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    Reset = 0;
    repeat (3) @(posedge Clk);
    #1;
    n_cmp++;
    if (rom_addr !== 19'd0 || pixel_on !== 1'b0 || pixel_rgb !== 24'd0 || pix_valid_out !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got addr=%0d on=%0b rgb=%h v=%0b want all 0",
               rom_addr, pixel_on, pixel_rgb, pix_valid_out);
    end
    Reset = 1;
    reset_model();
    tank_x = 10'd100; tank_y = 10'd50; tank_dir = 2'd0; tank_alive = 1;
    for (int i = 0; i < 6; i++) cycle(100 + i, 52, 1, 0, 0);
    n_cmp++;
    if (pixel_on !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_no_draw: got pixel_on=%0b want 0", pixel_on);
    end
  endtask

  task automatic test_directions();
    logic [18:0] want [4];
    want[0] = 19'd67; want[1] = 19'd898; want[2] = 19'd956; want[3] = 19'd125;
    for (int d = 0; d < 4; d++) begin
      tank_dir = 2'(d);
      cycle(0, 0, 0, 1, 0);
      cycle(103, 52, 1, 0, 0);
      n_cmp++;
      if (rom_addr !== want[d]) begin
        n_bad++;
        $display("FAIL dir%0d_addr: got %0d want %0d", d, rom_addr, want[d]);
      end
      idle(2);
      n_cmp++;
      if (pixel_on !== 1'b1 || pixel_rgb !== mem[want[d]]) begin
        n_bad++;
        $display("FAIL dir%0d_pixel: got on=%0b rgb=%h want on=1 rgb=%h", d, pixel_on, pixel_rgb, mem[want[d]]);
      end
    end
  endtask

  task automatic test_key_and_clip();
    tank_dir = 2'd0;
    cycle(0, 0, 0, 1, 0);
    cycle(101, 50, 1, 0, 0);
    idle(2);
    n_cmp++;
    if (pixel_on !== 1'b0 || pixel_rgb !== 24'd0) begin
      n_bad++;
      $display("FAIL key_transparent: got on=%0b rgb=%h want on=0 rgb=0", pixel_on, pixel_rgb);
    end
    cycle(99, 52, 1, 0, 0);
    n_cmp++;
    if (rom_addr !== 19'd0) begin
      n_bad++;
      $display("FAIL clip_left_addr: got %0d want 0", rom_addr);
    end
    idle(2);
    n_cmp++;
    if (pixel_on !== 1'b0 || pix_valid_out !== 1'b1) begin
      n_bad++;
      $display("FAIL clip_left_pixel: got on=%0b v=%0b want on=0 v=1", pixel_on, pix_valid_out);
    end
  endtask

  task automatic test_midframe_update();
    tank_x = 10'd200;
    cycle(201, 51, 1, 0, 0);
    n_cmp++;
    if (rom_addr !== 19'd0) begin
      n_bad++;
      $display("FAIL midframe_ignored: got %0d want 0", rom_addr);
    end
    cycle(201, 51, 1, 1, 0);
    n_cmp++;
    if (rom_addr !== 19'd0) begin
      n_bad++;
      $display("FAIL same_cycle_old_state: got %0d want 0", rom_addr);
    end
    cycle(201, 51, 1, 0, 0);
    n_cmp++;
    if (rom_addr !== 19'd33) begin
      n_bad++;
      $display("FAIL after_frame_start: got %0d want 33", rom_addr);
    end
    idle(2);
    tank_x = 10'd100;
    cycle(0, 0, 0, 1, 0);
  endtask

  task automatic test_blink();
    bit shown;
    tank_x = 10'd100; tank_y = 10'd50; tank_dir = 2'd0; tank_alive = 1;
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 1);
    for (int k = 1; k <= 10; k++) begin
      cycle(0, 0, 0, 1, 0);
      cycle(103, 52, 1, 0, 0);
      idle(2);
`ifdef TANK_BLINK_EN
      shown = (k > 4);
`else
      shown = 1;
`endif
      n_cmp++;
      if (pixel_on !== shown) begin
        n_bad++;
        $display("FAIL blink_frame%0d: got pixel_on=%0b want %0b", k, pixel_on, shown);
      end
    end
  endtask

  task automatic test_reset_midline();
    for (int i = 0; i < 3; i++) cycle(103 + i, 52, 1, 0, 0);
    DrawX = 10'd104; pix_valid_in = 1;
    #1 Reset = 0;
    #1;
    n_cmp++;
    if (rom_addr !== 19'd0 || pixel_on !== 1'b0 || pixel_rgb !== 24'd0 || pix_valid_out !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_midline_async: got addr=%0d on=%0b rgb=%h v=%0b want all 0",
               rom_addr, pixel_on, pixel_rgb, pix_valid_out);
    end
    repeat (3) @(posedge Clk);
    #1 Reset = 1;
    reset_model();
    for (int i = 0; i < 5; i++) cycle(103, 52, 1, 0, 0);
    n_cmp++;
    if (pixel_on !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_no_stale: got pixel_on=%0b want 0", pixel_on);
    end
    cycle(0, 0, 0, 1, 0);
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 30; f++) begin
      tank_x = 10'($urandom_range(0, 1023));
      tank_y = 10'($urandom_range(0, 1023));
      tank_dir = 2'($urandom);
      tank_alive = ($urandom_range(0, 5) != 0);
      cycle(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'($urandom), 1, 0);
      for (int p = 0; p < 150; p++) begin
        if ($urandom_range(0, 40) == 0) begin
          tank_x = 10'($urandom);
          tank_y = 10'($urandom);
          tank_dir = 2'($urandom);
        end
        cycle((mx + int'($urandom_range(0, 40)) - 4) & 1023,
              (my + int'($urandom_range(0, 40)) - 4) & 1023,
              ($urandom_range(0, 7) != 0), 0, ($urandom_range(0, 60) == 0));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 24'($urandom);
      if ($urandom_range(0, 4) == 0) mem[i] = KEY;
    end
    mem[67] = 24'h123456; mem[898] = 24'h00AA55; mem[956] = 24'h0F0F0F; mem[125] = 24'h777001;
    mem[1] = KEY; mem[33] = 24'h010203;
    reset_model();
    test_reset();
    test_directions();
    test_key_and_clip();
    test_midframe_update();
    test_blink();
    test_reset_midline();
    test_random_frames();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
